// File: rtl/debug_mem_loader.sv
// debug_mem_loader: byte-stream debug loader for the instruction and data RAMs.
// Frames are a command byte, a 4-byte little-endian address and, for writes,
// a 4-byte little-endian data word. Also controls the core reset level and
// keeps a sticky error flag.
// Optional readback (command 0x03 and the Tx byte stream) is compiled in when
// the macro DEBUG_LOADER_READBACK_EN is defined.
module debug_mem_loader (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  output logic [31:0] InstA2,
  output logic [31:0] InstWD2,
  output logic [3:0]  InstWE2,
  output logic [31:0] DataA2,
  output logic [31:0] DataWD2,
  output logic [3:0]  DataWE2,
  input  logic [31:0] DataRD2,
  output logic        CoreRst,
  output logic        Busy,
  output logic        Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE
`ifdef DEBUG_LOADER_READBACK_EN
    ,
    S_RDREQ,
    S_RDCAP,
    S_TX
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        core_rst;
  logic        err;
  logic        rx_en;
  logic        rx_fire;
  logic        frame_cmd;

`ifdef DEBUG_LOADER_READBACK_EN
  logic [31:0] shreg;
  assign TxData = shreg[7:0];
`else
  logic unused_rd;
  assign TxData    = '0;
  assign unused_rd = ^{TxReady, DataRD2};
`endif

  // rx_en holds RxReady low during reset and until the first edge after release
  assign RxReady = rx_en & ((state == S_IDLE) | (state == S_ADDR) | (state == S_DATA));
  assign rx_fire = RxValid & RxReady;

  assign InstA2  = addr;
  assign DataA2  = addr;
  assign InstWD2 = wdata;
  assign DataWD2 = wdata;
  assign CoreRst = core_rst;
  assign Err     = err;
  assign Busy    = (state != S_IDLE);

  // Decode command bytes that open an address/data frame
  always_comb begin
    frame_cmd = 1'b0;
    case (RxData)
      8'h01, 8'h02: frame_cmd = 1'b1;
`ifdef DEBUG_LOADER_READBACK_EN
      8'h03:        frame_cmd = 1'b1;
`endif
      default:      frame_cmd = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_nxt = state;
    InstWE2   = '0;
    DataWE2   = '0;
    TxValid   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_fire && frame_cmd) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (rx_fire && cnt == 2'd3) begin
`ifdef DEBUG_LOADER_READBACK_EN
          state_nxt = (op == 2'd3) ? S_RDREQ : S_DATA;
`else
          state_nxt = S_DATA;
`endif
        end
      end
      S_DATA: begin
        if (rx_fire && cnt == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (op == 2'd1) InstWE2 = '1;
        if (op == 2'd2) DataWE2 = '1;
        state_nxt = S_IDLE;
      end
`ifdef DEBUG_LOADER_READBACK_EN
      S_RDREQ: state_nxt = S_RDCAP;
      S_RDCAP: state_nxt = S_TX;
      S_TX: begin
        TxValid = 1'b1;
        if (TxReady && cnt == 2'd3) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame assembly, core-reset control, error flag and readback shifter
  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      rx_en    <= 1'b0;
      cnt      <= '0;
      op       <= '0;
      addr     <= '0;
      wdata    <= '0;
      core_rst <= 1'b1;
      err      <= 1'b0;
`ifdef DEBUG_LOADER_READBACK_EN
      shreg    <= '0;
`endif
    end else begin
      rx_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            cnt <= '0;
            if (frame_cmd) begin
              op <= RxData[1:0];
            end else begin
              case (RxData)
                8'h04:   core_rst <= 1'b0;
                8'h05:   core_rst <= 1'b1;
                8'h06:   err      <= 1'b0;
                default: err      <= 1'b1;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr[{cnt, 3'b000} +: 8] <= RxData;
            // later assignment wins: keeps the stored address word-aligned
            addr[1:0] <= 2'b00;
            cnt <= cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            wdata[{cnt, 3'b000} +: 8] <= RxData;
            cnt <= cnt + 2'd1;
          end
        end
`ifdef DEBUG_LOADER_READBACK_EN
        S_RDCAP: begin
          shreg <= DataRD2;
          cnt   <= '0;
        end
        S_TX: begin
          if (TxReady) begin
            shreg <= {8'h00, shreg[31:8]};
            cnt   <= cnt + 2'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/debug_mem_loader.md
DEBUG_MEM_LOADER -- requirements
Module: debug_mem_loader

Interface
REQ-001 CPU_CLK  in  1  sole clock; all state changes on rising edge.
REQ-002 CPU_RST  in  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-003 RxData  in  8, RxValid  in  1, RxReady  out  1: command byte stream; a byte transfers on a cycle with RxValid=1 and RxReady=1.
REQ-004 TxData  out  8, TxValid  out  1, TxReady  in  1: readback byte stream; a byte transfers on a cycle with TxValid=1 and TxReady=1.
REQ-005 InstA2 / InstWD2  out  32 each, InstWE2  out  4: instruction-RAM debug port.
REQ-006 DataA2 / DataWD2  out  32 each, DataWE2  out  4, DataRD2  in  32: data-RAM debug port; RAM read is synchronous, 1-cycle latency.
REQ-007 CoreRst  out  1: active-high reset level for the core; 1 = core held.
REQ-008 Busy  out  1 (state != IDLE); Err  out  1 (sticky error flag).

Function
REQ-009 Frame: command byte, then 4 address bytes, then 4 data bytes for writes; every multi-byte field is little-endian (first byte = bits 7:0).
REQ-010 Commands: 0x01 write InstRAM; 0x02 write DataRAM; 0x03 read DataRAM (address only, no data bytes); 0x04 RUN (CoreRst<=0); 0x05 HALT (CoreRst<=1); 0x06 clear Err.
REQ-011 States: IDLE, ADDR, DATA, WRITE, RDREQ, RDCAP, TX.
REQ-012 IDLE: RxReady=1; a byte of 0x01/0x02/0x03 goes to ADDR with byte counter 0; 0x04/0x05/0x06 act in the following cycle and stay IDLE; any other value sets Err and stays IDLE.
REQ-013 ADDR/DATA: RxReady=1; a 2-bit counter selects the byte lane; the 4th byte moves ADDR->DATA (writes) or ADDR->RDREQ (read), and DATA->WRITE; the counter wraps to 0 at each field boundary.
REQ-014 Address bits 1:0 are forced to 0 on A2 outputs (word-aligned access only).
REQ-015 WRITE: exactly one cycle; the selected WE2 = 4'b1111 with A2/WD2 valid; the other port's WE2 = 0; returns to IDLE next cycle.
REQ-016 WE2 outputs are 0 in every state other than WRITE.
REQ-017 RDREQ drives DataA2 for one cycle; RDCAP latches DataRD2 into a 32-bit shift register; then TX.
REQ-018 TX: RxReady=0, TxValid=1, TxData = current byte (LSB first); the byte advances only on a handshake; after the 4th handshake, go to IDLE. TxValid=0 in all other states.
REQ-019 A RUN or HALT received while the core is already in that state has no effect and does not set Err.
REQ-020 A WRITE issued while CoreRst=0 still executes; the CoreRst level is unchanged.
REQ-021 RxReady=0 in WRITE, RDREQ, RDCAP and TX; bytes are never dropped or reordered.
REQ-022 InstA2 and DataA2 hold the last assembled address between operations.

Reset
REQ-023 With CPU_RST=0, outputs are forced immediately, without waiting for a clock edge: state IDLE, counter 0, CoreRst=1, Err=0, TxValid=0, RxReady=0, WE2=0, address and data registers 0.
REQ-024 RxReady becomes 1 on the first edge after CPU_RST rises.
REQ-025 Reset mid-frame discards the partial frame.
REQ-026 Reset mid-TX drops the remaining bytes with no further TxValid.

Configuration
REQ-027 Macro DEBUG_LOADER_READBACK_EN defined: 0x03 is legal, and RDREQ, RDCAP, TX and the Tx ports are active.
REQ-028 Macro DEBUG_LOADER_READBACK_EN undefined: 0x03 sets Err like any illegal command, TxValid is tied 0, TxData is tied 0, and the RD/TX states are omitted.

Verification
REQ-029 Reset release, then frame 01 10 00 00 00 EF BE AD DE -> one cycle with InstWE2=F, InstA2=0x10, InstWD2=0xDEADBEEF; DataWE2 stays 0.
REQ-030 Frame 02 07 00 00 00 78 56 34 12 -> DataA2=0x04 (bits 1:0 forced 0), DataWD2=0x12345678, DataWE2=F for exactly one cycle.
REQ-031 (readback enabled) DataRD2=0xCAFEF00D, frame 03 04 00 00 00, TxReady held 0 for 3 cycles then 1 -> TxData 0D stable while stalled, then 0D, F0, FE, CA on 4 handshakes; then IDLE.
REQ-032 Byte 0x04 -> CoreRst 1->0; byte 0x05 -> CoreRst 0->1; byte 0x7F -> Err=1, still IDLE; byte 0x06 -> Err=0.
REQ-033 CPU_RST=0 after the 6th byte of a write frame -> no WE2 pulse, CoreRst=1; a new full frame after release writes correctly.
